// File: rtl/mem_resp_pkg.sv
// Shared types and sizing for the mem_responder memory target.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int WAIT_MAX   = 7;
  localparam int CNT_W      = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/resp_mem_array.sv
// Storage for mem_responder: synchronous write, registered read; contents are never reset.
module resp_mem_array #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Only the read register is reset so rdata starts at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder with WAIT_CYCLES wait states before a one-cycle ack.
// Optional stored-parity checking is enabled with `define MEM_RESP_PARITY_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef MEM_RESP_PARITY_EN
  input  logic              inj_parity_err,
`endif
  output logic              busy,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_oe,
  output logic              err
);

`ifdef MEM_RESP_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = DATA_W + PAR_W;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  op_e                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                busy_q, ack_q, oe_q, err_q;

  logic                in_idle, start, proto_err, commit, cur_wr;
  logic [ADDR_W-1:0]   cur_addr;
  logic [DATA_W-1:0]   cur_wdata;
  logic                mem_we, mem_re;
  logic [WORD_W-1:0]   mem_wword, mem_rword;

`ifdef MEM_RESP_PARITY_EN
  logic inj_q;
  logic cur_inj;
`endif

  // With zero wait states the commit edge is the request edge, so the
  // commit path takes the live request instead of the latched copy.
  always_comb begin
    in_idle   = (state_q == IDLE);
    start     = in_idle && (req_rd ^ req_wr);
    proto_err = in_idle && req_rd && req_wr;
    cur_wr    = in_idle ? req_wr    : (op_q == OP_WR);
    cur_addr  = in_idle ? req_addr  : addr_q;
    cur_wdata = in_idle ? req_wdata : wdata_q;
    commit    = !rst && ((start && (WAIT_CYCLES == 0)) ||
                         ((state_q == WAIT) && (cnt_q == '0)));
    mem_we    = commit && cur_wr;
    mem_re    = commit && !cur_wr;
`ifdef MEM_RESP_PARITY_EN
    cur_inj   = in_idle ? inj_parity_err : inj_q;
    mem_wword = {(^cur_wdata) ^ cur_inj, cur_wdata};
`else
    mem_wword = cur_wdata;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 1'b0;
          oe_q  <= 1'b0;
          err_q <= proto_err;
          if (start) begin
            busy_q <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_q <= ACK;
              ack_q   <= 1'b1;
              oe_q    <= req_rd;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          err_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q <= ACK;
            ack_q   <= 1'b1;
            oe_q    <= (op_q == OP_RD);
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          ack_q   <= 1'b0;
          oe_q    <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op_q    <= req_wr ? OP_WR : OP_RD;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
`ifdef MEM_RESP_PARITY_EN
      inj_q   <= inj_parity_err;
`endif
    end
  end

  resp_mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (cur_addr),
    .wdata (mem_wword),
    .rdata (mem_rword)
  );

  assign busy     = busy_q;
  assign ack      = ack_q;
  assign rdata_oe = oe_q;
  assign rdata    = mem_rword[DATA_W-1:0];
`ifdef MEM_RESP_PARITY_EN
  assign err = err_q | (ack_q & oe_q & (mem_rword[DATA_W] ^ (^mem_rword[DATA_W-1:0])));
`else
  assign err = err_q;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) share one stimulus stream
// and are checked every cycle against a timestamp-based transaction model.
module tb_mem_responder;

  logic       clk;
  logic       rst, req_rd, req_wr, inj;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;

  logic       busy2, ack2, oe2, err2;
  logic [7:0] rdata2;
  logic       busy0, ack0, oe0, err0;
  logic [7:0] rdata0;

  int vectors = 0;
  int fails   = 0;

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(2)) d2 (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_RESP_PARITY_EN
    .inj_parity_err(inj),
`endif
    .busy(busy2), .ack(ack2), .rdata(rdata2), .rdata_oe(oe2), .err(err2)
  );

  mem_responder #(.ADDR_W(5), .DATA_W(8), .WAIT_CYCLES(0)) d0 (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef MEM_RESP_PARITY_EN
    .inj_parity_err(inj),
`endif
    .busy(busy0), .ack(ack0), .rdata(rdata0), .rdata_oe(oe0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a transaction accepted in cycle t acks in cycle t+W+1 and the
  // DUT samples again from cycle t+W+2. Index 0 is d2, index 1 is d0.
  int         W [2] = '{2, 0};
  logic [7:0] m_mem [2][32];
  bit         m_bad [2][32];
  bit         pend  [2];
  int         ccyc  [2];
  bit         pwr   [2];
  bit         pinj  [2];
  logic [4:0] padr  [2];
  logic [7:0] pdat  [2];
  bit         e_busy [2];
  bit         e_ack  [2];
  bit         e_oe   [2];
  bit         e_err  [2];
  logic [7:0] e_rd   [2];
  int         n = 0;
  bit         mvalid = 1'b0;

  task automatic model_edge(input int k);
    e_err[k] = 1'b0;
    e_ack[k] = 1'b0;
    e_oe[k]  = 1'b0;
    if (rst) begin
      pend[k]   = 1'b0;
      e_busy[k] = 1'b0;
      e_rd[k]   = 8'h00;
    end else begin
      if (pend[k] && n == ccyc[k]) begin
        pend[k] = 1'b0;
      end else if (!pend[k]) begin
        if (req_rd ^ req_wr) begin
          pend[k] = 1'b1;
          ccyc[k] = n + W[k] + 1;
          pwr[k]  = req_wr;
          padr[k] = req_addr;
          pdat[k] = req_wdata;
          pinj[k] = inj;
        end
        e_err[k] = req_rd & req_wr;
      end
      e_busy[k] = pend[k];
      if (pend[k] && ccyc[k] == n + 1) begin
        e_ack[k] = 1'b1;
        if (pwr[k]) begin
          m_mem[k][padr[k]] = pdat[k];
          m_bad[k][padr[k]] = pinj[k];
        end else begin
          e_rd[k] = m_mem[k][padr[k]];
          e_oe[k] = 1'b1;
`ifdef MEM_RESP_PARITY_EN
          e_err[k] = m_bad[k][padr[k]];
`endif
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_edge(0);
    model_edge(1);
    n = n + 1;
    if (rst) mvalid = 1'b1;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic b, input logic a, input logic o,
                     input logic e, input logic [7:0] r);
    chk($sformatf("busy[%0d]", k),     b, e_busy[k]);
    chk($sformatf("ack[%0d]", k),      a, e_ack[k]);
    chk($sformatf("rdata_oe[%0d]", k), o, e_oe[k]);
    chk($sformatf("err[%0d]", k),      e, e_err[k]);
    chk($sformatf("rdata[%0d]", k),    r, e_rd[k]);
  endtask

  always @(negedge clk) begin
    if (mvalid) begin
      cmp(0, busy2, ack2, oe2, err2, rdata2);
      cmp(1, busy0, ack0, oe0, err0, rdata0);
    end
  end

  // Apply inputs for the current cycle, then advance to just after the next edge.
  task automatic step(input logic r, input logic rd, input logic wr,
                      input logic [4:0] a, input logic [7:0] d, input logic ij);
    rst = r; req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d; inj = ij;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cnt);
    for (int i = 0; i < cnt; i++) step(0, 0, 0, 5'h00, 8'h00, 0);
  endtask

  task automatic wr_op(input logic [4:0] a, input logic [7:0] d, input logic ij);
    step(0, 0, 1, a, d, ij);
    idle(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] mask2, mask0;

  initial begin
    rst = 1; req_rd = 0; req_wr = 0; req_addr = '0; req_wdata = '0; inj = 0;
    #1;
    step(1, 0, 0, 5'h00, 8'h00, 0);
    step(1, 0, 0, 5'h00, 8'h00, 0);
    chk("rst_busy", busy2, 0);  chk("rst_ack", ack2, 0);
    chk("rst_rdata", rdata2, 8'h00); chk("rst_oe", oe2, 0);
    chk("rst_err", err2, 0);    chk("rst_busy0", busy0, 0);
    chk("rst_rdata0", rdata0, 8'h00);

    wr_op(5'h01, 8'h3E, 0);
    wr_op(5'h04, 8'h77, 0);

    // write 0xA5 to 0x0A, WAIT_CYCLES=2
    step(0, 0, 1, 5'h0A, 8'hA5, 0);
    chk("wr_c1_busy", busy2, 1); chk("wr_c1_ack", ack2, 0);
    idle(1);
    chk("wr_c2_busy", busy2, 1); chk("wr_c2_ack", ack2, 0);
    idle(1);
    chk("wr_c3_ack", ack2, 1); chk("wr_c3_busy", busy2, 1); chk("wr_c3_oe", oe2, 0);
    idle(1);
    chk("wr_c4_busy", busy2, 0); chk("wr_c4_ack", ack2, 0);

    // read 0x0A on both instances
    step(0, 1, 0, 5'h0A, 8'h00, 0);
    chk("rd0_c1_ack", ack0, 1); chk("rd0_c1_busy", busy0, 1);
    chk("rd0_c1_rdata", rdata0, 8'hA5); chk("rd0_c1_oe", oe0, 1);
    chk("rd_c1_ack", ack2, 0);
    idle(1);
    chk("rd0_c2_busy", busy0, 0); chk("rd0_c2_oe", oe0, 0);
    chk("rd_c2_oe", oe2, 0);
    idle(1);
    chk("rd_c3_ack", ack2, 1); chk("rd_c3_oe", oe2, 1); chk("rd_c3_rdata", rdata2, 8'hA5);
    idle(1);
    chk("rd_c4_oe", oe2, 0); chk("rd_c4_hold", rdata2, 8'hA5); chk("rd_c4_busy", busy2, 0);

    // simultaneous rd and wr at 0x04
    step(0, 1, 1, 5'h04, 8'hEE, 0);
    chk("proto_err", err2, 1); chk("proto_busy", busy2, 0);
    chk("proto_ack", ack2, 0); chk("proto_err0", err0, 1);
    idle(1);
    chk("proto_err_clr", err2, 0);
    step(0, 1, 0, 5'h04, 8'h00, 0);
    idle(2);
    chk("proto_rd_ack", ack2, 1); chk("proto_rd_val", rdata2, 8'h77);
    idle(1);

    // held read at 0x01 for cycles 0..7
    mask2 = '0; mask0 = '0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 5'h01, 8'h00, 0);
      mask2[i] = ack2;
      mask0[i] = ack0;
    end
    chk("held_ack_mask2", mask2, 8'h44);
    chk("held_ack_mask0", mask0, 8'h55);
    chk("held_rdata", rdata2, 8'h3E);
    idle(2);

    // reset aborts an uncommitted write
    wr_op(5'h1F, 8'h00, 0);
    step(0, 0, 1, 5'h1F, 8'h3C, 0);
    chk("abort_c1_busy", busy2, 1); chk("abort_c1_ack0", ack0, 1);
    step(1, 0, 0, 5'h00, 8'h00, 0);
    chk("abort_busy", busy2, 0); chk("abort_ack", ack2, 0);
    idle(3);
    step(0, 1, 0, 5'h1F, 8'h00, 0);
    idle(2);
    chk("abort_rd_ack", ack2, 1); chk("abort_rd_val", rdata2, 8'h00);
    chk("abort_rd_val0", rdata0, 8'h3C);
    idle(1);

`ifdef MEM_RESP_PARITY_EN
    wr_op(5'h02, 8'h55, 1);
    step(0, 1, 0, 5'h02, 8'h00, 0);
    idle(2);
    chk("par_bad_ack", ack2, 1); chk("par_bad_err", err2, 1);
    chk("par_bad_rdata", rdata2, 8'h55);
    idle(1);
    wr_op(5'h02, 8'h55, 0);
    step(0, 1, 0, 5'h02, 8'h00, 0);
    idle(2);
    chk("par_ok_ack", ack2, 1); chk("par_ok_err", err2, 0);
    chk("par_ok_rdata", rdata2, 8'h55);
    idle(1);
`endif

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
